// File: rtl/phoenix_switch_ctrl.sv
// Switch control for a 5-port Phoenix router: round-robin header arbitration,
// XY routing, output reservation and release when the packet ends.
module phoenix_switch_ctrl #(
    parameter int                  TAM_FLIT = 16,
    parameter int                  NPORT    = 5,
    parameter logic [TAM_FLIT-1:0] ADDRESS  = '0
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [NPORT-1:0]          h,
    input  logic [NPORT*TAM_FLIT-1:0] data_in_hdr,
    input  logic [NPORT-1:0]          sender,
    output logic [NPORT-1:0]          ack_h,
    output logic [NPORT-1:0]          out_busy,
    output logic [NPORT*3-1:0]        sel_in,
    output logic [NPORT*3-1:0]        in_sel_out
);
    localparam int         HALF = TAM_FLIT / 2;
    localparam logic [2:0] NONE = 3'b111;

    typedef enum logic [1:0] {S_IDLE, S_ARB, S_ROUTE, S_GRANT} state_t;

    state_t               r_state;
    state_t               w_state_next;
    logic [2:0]           r_ptr;
    logic [2:0]           r_win;
    logic [2:0]           r_dest;
    logic [NPORT-1:0]     r_sender_q;
    logic [NPORT-1:0]     r_ack_h;
    logic [NPORT-1:0]     r_out_busy;
    logic [NPORT*3-1:0]   r_sel_in;
    logic [NPORT*3-1:0]   r_in_sel_out;

    logic [2:0]           w_win;
    logic [2:0]           w_cand;
    logic                 w_found;
    logic [TAM_FLIT-1:0]  w_hdr;
    logic [HALF-1:0]      w_tx;
    logic [HALF-1:0]      w_ty;
    logic [2:0]           w_route;
    logic                 w_load_win;
    logic                 w_load_dest;
    logic                 w_grant;
    logic [2:0]           w_src [NPORT];
    logic [NPORT-1:0]     w_release;
    logic [NPORT-1:0]     w_in_release;

    // FSM: state register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM: next state
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (|h) w_state_next = S_ARB;
            S_ARB:   w_state_next = (|h) ? S_ROUTE : S_IDLE;
            S_ROUTE: w_state_next = S_GRANT;
            S_GRANT: w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // FSM: control outputs; the grant sees busy flags from before any same-cycle release
    always_comb begin
        w_load_win  = (r_state == S_ARB) && (|h);
        w_load_dest = (r_state == S_ROUTE);
        w_grant     = (r_state == S_GRANT) && h[r_win] && !r_out_busy[r_dest];
    end

    // Round-robin search starting just after the last winner
    always_comb begin
        w_win   = r_ptr;
        w_found = 1'b0;
        w_cand  = r_ptr;
        for (int k = 1; k <= NPORT; k++) begin
            w_cand = 3'((int'(r_ptr) + k) % NPORT);
            if (!w_found && h[w_cand]) begin
                w_win   = w_cand;
                w_found = 1'b1;
            end
        end
    end

    // XY routing: resolve X first, then Y, otherwise deliver locally
    always_comb begin
        w_hdr = data_in_hdr[int'(r_win)*TAM_FLIT +: TAM_FLIT];
        w_tx  = w_hdr[TAM_FLIT-1:HALF];
        w_ty  = w_hdr[HALF-1:0];
        if (w_tx > ADDRESS[TAM_FLIT-1:HALF])      w_route = 3'd0;
        else if (w_tx < ADDRESS[TAM_FLIT-1:HALF]) w_route = 3'd1;
        else if (w_ty > ADDRESS[HALF-1:0])        w_route = 3'd2;
        else if (w_ty < ADDRESS[HALF-1:0])        w_route = 3'd3;
        else                                      w_route = 3'd4;
    end

    // A connection ends on the falling edge of its source's sender flag
    generate
        for (genvar gi = 0; gi < NPORT; gi++) begin : g_release
            assign w_src[gi]     = r_sel_in[gi*3 +: 3];
            assign w_release[gi] = r_out_busy[gi] && r_sender_q[w_src[gi]] && !sender[w_src[gi]];

            a_no_rehdr: assert property (@(posedge clock) disable iff (!reset)
                !(h[gi] && (r_in_sel_out[gi*3 +: 3] != NONE) && !r_ack_h[gi]));
        end
    endgenerate

    always_comb begin
        w_in_release = '0;
        for (int o = 0; o < NPORT; o++) begin
            if (w_release[o]) w_in_release[w_src[o]] = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_ptr        <= 3'(NPORT - 1);
            r_win        <= '0;
            r_dest       <= '0;
            r_sender_q   <= '0;
            r_ack_h      <= '0;
            r_out_busy   <= '0;
            r_sel_in     <= {NPORT{NONE}};
            r_in_sel_out <= {NPORT{NONE}};
        end else begin
            r_sender_q <= sender;
            r_ack_h    <= '0;
            if (w_load_win) begin
                r_ptr <= w_win;
                r_win <= w_win;
            end
            if (w_load_dest) r_dest <= w_route;
            for (int o = 0; o < NPORT; o++) begin
                if (w_release[o]) begin
                    r_out_busy[o]       <= 1'b0;
                    r_sel_in[o*3 +: 3]  <= NONE;
                end
                if (w_in_release[o]) r_in_sel_out[o*3 +: 3] <= NONE;
            end
            if (w_grant) begin
                r_out_busy[r_dest]                 <= 1'b1;
                r_sel_in[int'(r_dest)*3 +: 3]      <= r_win;
                r_in_sel_out[int'(r_win)*3 +: 3]   <= r_dest;
                r_ack_h[r_win]                     <= 1'b1;
            end
        end
    end

    assign ack_h      = r_ack_h;
    assign out_busy   = r_out_busy;
    assign sel_in     = r_sel_in;
    assign in_sel_out = r_in_sel_out;

endmodule

// File: tb/tb_phoenix_switch_ctrl.sv
// Bench for phoenix_switch_ctrl: a round-level connection-table model checked every
// cycle, plus directed scenarios with hand-computed literal expectations.
module tb_phoenix_switch_ctrl;
    localparam int          NPORT = 5;
    localparam int          TF    = 16;
    localparam logic [15:0] ADDR  = 16'h0101;

    logic                   clock;
    logic                   reset;
    logic [NPORT-1:0]       h;
    logic [NPORT*TF-1:0]    data_in_hdr;
    logic [NPORT-1:0]       sender;
    logic [NPORT-1:0]       ack_h;
    logic [NPORT-1:0]       out_busy;
    logic [NPORT*3-1:0]     sel_in;
    logic [NPORT*3-1:0]     in_sel_out;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    phoenix_switch_ctrl #(.TAM_FLIT(TF), .NPORT(NPORT), .ADDRESS(ADDR)) dut (
        .clock       (clock),
        .reset       (reset),
        .h           (h),
        .data_in_hdr (data_in_hdr),
        .sender      (sender),
        .ack_h       (ack_h),
        .out_busy    (out_busy),
        .sel_in      (sel_in),
        .in_sel_out  (in_sel_out)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Connection table per output (-1 = free); a round is a 4-step sequence
    // (wait / arbitrate / route / grant) tracked by a step counter.
    int               m_step = -1;
    int               m_ptr  = NPORT - 1;
    int               m_w    = 0;
    int               m_d    = 0;
    int               m_src     [NPORT] = '{default: -1};
    int               m_src_pre [NPORT] = '{default: -1};
    bit               m_rel     [NPORT];
    bit               m_g;
    bit               m_found;
    logic [NPORT-1:0] m_prev_sender = '0;
    logic [NPORT-1:0] m_ack = '0;

    function automatic int route_of(input logic [15:0] f);
        logic [15:0] a;
        int tx, ty, ax, ay;
        a  = ADDR;
        tx = int'(f[15:8]);
        ty = int'(f[7:0]);
        ax = int'(a[15:8]);
        ay = int'(a[7:0]);
        if (tx > ax) return 0;
        if (tx < ax) return 1;
        if (ty > ay) return 2;
        if (ty < ay) return 3;
        return 4;
    endfunction

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            m_step = -1;
            m_ptr  = NPORT - 1;
            m_ack  = '0;
            m_prev_sender = '0;
            for (int o = 0; o < NPORT; o++) m_src[o] = -1;
        end else begin
            m_src_pre = m_src;
            m_g = 0;
            for (int o = 0; o < NPORT; o++)
                m_rel[o] = (m_src_pre[o] >= 0) && m_prev_sender[m_src_pre[o]] && !sender[m_src_pre[o]];
            case (m_step)
                -1: if (h != 0) m_step = 0;
                0: begin
                    if (h == 0) m_step = -1;
                    else begin
                        m_found = 0;
                        for (int k = 1; k <= NPORT; k++) begin
                            if (!m_found && h[(m_ptr + k) % NPORT]) begin
                                m_w = (m_ptr + k) % NPORT;
                                m_found = 1;
                            end
                        end
                        m_ptr  = m_w;
                        m_step = 1;
                    end
                end
                1: begin
                    m_d    = route_of(data_in_hdr[m_w*TF +: TF]);
                    m_step = 2;
                end
                default: begin
                    m_g    = h[m_w] && (m_src_pre[m_d] < 0);
                    m_step = -1;
                end
            endcase
            for (int o = 0; o < NPORT; o++) if (m_rel[o]) m_src[o] = -1;
            if (m_g) m_src[m_d] = m_w;
            m_ack = m_g ? NPORT'(1 << m_w) : '0;
            m_prev_sender = sender;
        end
    end

    // Per-cycle comparison against the model, away from the active edge
    always @(negedge clock) begin : cmp
        logic [NPORT-1:0]   eb;
        logic [NPORT*3-1:0] es;
        logic [NPORT*3-1:0] ei;
        eb = '0;
        es = '1;
        ei = '1;
        for (int o = 0; o < NPORT; o++) begin
            if (m_src[o] >= 0) begin
                eb[o]          = 1'b1;
                es[o*3 +: 3]   = 3'(m_src[o]);
                ei[m_src[o]*3 +: 3] = 3'(o);
            end
        end
        chk("model_ack_h", 32'(ack_h), 32'(m_ack));
        chk("model_out_busy", 32'(out_busy), 32'(eb));
        chk("model_sel_in", 32'(sel_in), 32'(es));
        chk("model_in_sel_out", 32'(in_sel_out), 32'(ei));
        if (ack_h != 0)
            $display("grant: ack_h=%b out_busy=%b sel_in=%h in_sel_out=%h", ack_h, out_busy, sel_in, in_sel_out);
    end

    // ---------------- directed stimulus ----------------
    task automatic request(input int i, input logic [15:0] hdr);
        data_in_hdr[i*TF +: TF] = hdr;
        h[i] = 1'b1;
    endtask

    task automatic wait_ack(input int i, output int stamp);
        stamp = -1;
        for (int n = 0; n < 40; n++) begin
            @(posedge clock);
            #1;
            if (ack_h[i]) begin
                stamp = cyc;
                h[i]  = 1'b0;
                break;
            end
        end
        if (stamp < 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL ack_timeout: input %0d got no ack_h, expected one within 40 cycles", i);
            h[i] = 1'b0;
        end
    endtask

    task automatic grant_one(input int i, input logic [15:0] hdr, input int d);
        int t0, s;
        @(negedge clock);
        request(i, hdr);
        t0 = cyc;
        wait_ack(i, s);
        chk("latency", 32'(s - t0 - 1), 32'd3);
        chk("ack_onehot", 32'(ack_h), 32'(1 << i));
        chk("busy_set", 32'(out_busy[d]), 32'd1);
        chk("sel_in_src", 32'(sel_in[d*3 +: 3]), 32'(i));
        chk("in_sel_out_dst", 32'(in_sel_out[i*3 +: 3]), 32'(d));
        @(posedge clock);
        #1;
        chk("ack_one_cycle", 32'(ack_h), 32'd0);
    endtask

    task automatic finish_pkt(input int i, input int d);
        @(negedge clock);
        sender[i] = 1'b1;
        repeat (2) @(negedge clock);
        sender[i] = 1'b0;
        @(posedge clock);
        #1;
        chk("release_busy", 32'(out_busy[d]), 32'd0);
        chk("release_map", 32'(in_sel_out[i*3 +: 3]), 32'd7);
    endtask

    initial begin
        int s0, s2, s3;
        reset = 1'b0;
        h = '0;
        sender = '0;
        data_in_hdr = '0;

        // 1: reset state
        repeat (3) @(negedge clock);
        chk("rst_ack_h", 32'(ack_h), 32'd0);
        chk("rst_out_busy", 32'(out_busy), 32'd0);
        reset = 1'b1;
        @(negedge clock);
        chk("rst_sel_in", 32'(sel_in), 32'h7fff);
        chk("rst_in_sel_out", 32'(in_sel_out), 32'h7fff);

        // 2: LOCAL header to EAST
        grant_one(4, 16'h0201, 0);
        finish_pkt(4, 0);

        // 3: LOCAL, SOUTH and WEST destinations
        grant_one(4, 16'h0101, 4);
        finish_pkt(4, 4);
        grant_one(4, 16'h0100, 3);
        finish_pkt(4, 3);
        grant_one(4, 16'h0001, 1);
        finish_pkt(4, 1);

        // 4: two requests from ptr=4: input 0 then input 2 four cycles later
        @(negedge clock);
        request(0, 16'h0201);
        request(2, 16'h0102);
        wait_ack(0, s0);
        wait_ack(2, s2);
        chk("rr_spacing", 32'(s2 - s0), 32'd4);
        chk("rr_busy", 32'(out_busy), 32'b00101);
        chk("rr_sel_east", 32'(sel_in[2:0]), 32'd0);
        chk("rr_sel_north", 32'(sel_in[8:6]), 32'd2);
        finish_pkt(0, 0);
        finish_pkt(2, 2);

        // 5: input 3 blocked on EAST until input 1 finishes
        grant_one(1, 16'h0201, 0);
        @(negedge clock);
        sender[1] = 1'b1;
        request(3, 16'h0201);
        repeat (12) @(negedge clock);
        chk("blocked_owner", 32'(sel_in[2:0]), 32'd1);
        chk("blocked_map3", 32'(in_sel_out[11:9]), 32'd7);
        sender[1] = 1'b0;
        @(posedge clock);
        #1;
        chk("rel_busy", 32'(out_busy[0]), 32'd0);
        chk("rel_sel_in", 32'(sel_in[2:0]), 32'd7);
        chk("rel_map1", 32'(in_sel_out[5:3]), 32'd7);
        wait_ack(3, s3);
        chk("retry_sel_in", 32'(sel_in[2:0]), 32'd3);
        chk("retry_map3", 32'(in_sel_out[11:9]), 32'd0);

        // 6: reset during GRANT with a free destination
        repeat (3) @(negedge clock);
        request(4, 16'h0100);
        repeat (3) @(posedge clock);
        @(negedge clock);
        #2;
        reset = 1'b0;
        #1;
        chk("midrst_ack", 32'(ack_h), 32'd0);
        chk("midrst_busy", 32'(out_busy), 32'd0);
        chk("midrst_sel_in", 32'(sel_in), 32'h7fff);
        chk("midrst_in_sel_out", 32'(in_sel_out), 32'h7fff);
        @(posedge clock);
        #1;
        chk("midrst_no_pulse", 32'(ack_h), 32'd0);
        h = '0;
        @(negedge clock);
        reset = 1'b1;
        repeat (3) @(negedge clock);
        chk("post_rst_busy", 32'(out_busy), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        n_checks++;
        n_fail++;
        $display("FAIL watchdog: simulation still running at 200000, expected completion earlier");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/phoenix_switch_ctrl.md
Name: phoenix_switch_ctrl

Overview:
Switch-control block for one 5-port Phoenix router (EAST=0, WEST=1, NORTH=2, SOUTH=3, LOCAL=4). It arbitrates round-robin among input buffers presenting a header flit and computes the XY route from the header's target address. If the output port is free it reserves the port, acknowledges the header and drives crossbar select maps. It releases a connection when the owning input buffer finishes the packet. It sits beside the input buffers and crossbar inside the router instantiated per mesh node.

Parameters:
TAM_FLIT, 16, flit width in bits; the target address occupies the low TAM_FLIT bits of the header flit.
NPORT, 5, number of router ports; fixed at 5.
ADDRESS, 16'h0000, this router's address: {X,Y}, each TAM_FLIT/2 bits, X in the upper half.

Ports:
clock  input  1  router clock
reset  input  1  asynchronous, active-low reset
h  input  NPORT  input buffer i has a header flit at its head; held until ack_h[i]
data_in_hdr  input  NPORT*TAM_FLIT  head flit of each input buffer; port i at [i*TAM_FLIT +: TAM_FLIT]
sender  input  NPORT  input buffer i is forwarding a packet; rises after ack_h, falls after the tail flit
ack_h  output  NPORT  one-cycle header acknowledge to input i
out_busy  output  NPORT  output port o is reserved
sel_in  output  NPORT*3  for each output o, source input index; 3'b111 when free
in_sel_out  output  NPORT*3  for each input i, destination output index; 3'b111 when unconnected

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, ack_h=0, out_busy=0, every sel_in/in_sel_out field=3'b111, priority pointer ptr=NPORT-1, sender_q=0. All outputs are registered.
- FSM states: IDLE, ARB, ROUTE, GRANT.
- IDLE: if any h bit is 1, go to ARB; otherwise stay.
- ARB: pick the winner w, the first i with h[i]=1 searching ptr+1, ptr+2, … modulo NPORT. Set ptr=w; the pointer advances even if the grant later fails, to prevent starvation. Go to ROUTE. If h is now all zero, return to IDLE.
- ROUTE: take tX,tY from data_in_hdr[w]. Destination d is, in priority order:
  - tX>X → 0
  - tX<X → 1
  - tY>Y → 2
  - tY<Y → 3
  - otherwise → 4
  Compares are unsigned, TAM_FLIT/2 bits wide. Go to GRANT.
- GRANT:
  - If h[w]=1 and out_busy[d]=0 (value registered before this cycle): set out_busy[d]=1, sel_in[d]=w, in_sel_out[w]=d, and pulse ack_h[w]=1 for this cycle only.
  - Otherwise (port busy, or h[w] dropped): no ack, no change.
  - Always return to IDLE. A denied input retries on a later arbitration round.
- Latency: with h asserted while in IDLE, ack_h is high 3 cycles later (IDLE→ARB→ROUTE→GRANT). One grant at most per 4 cycles.
- Release: sender_q registers sender every cycle. For each output o with out_busy[o]=1 and source s=sel_in[o]: if sender_q[s]=1 and sender[s]=0, then next cycle out_busy[o]=0, sel_in[o]=3'b111, in_sel_out[s]=3'b111. Release runs in every FSM state and for all ports in parallel.
- Release and grant on the same output in the same cycle: the release wins and the grant is denied, because the grant checks pre-release busy. The request is retried.
- U-turn (d==w) is not filtered; the routing function never produces it for a valid mesh.
- An input that is already connected does not assert h again until it is released. This is a requirement on the input buffer; a controller assertion flags a violation.
- Reset mid-operation: all reservations drop immediately and any ack_h in flight is suppressed.

Test Plan:
1. Hold reset=0, then release it → out_busy=5'b0, ack_h=0, all sel fields 3'b111, state IDLE.
2. ADDRESS=16'h0101. Set h[4]=1 with header 16'h0201 → ack_h=5'b10000 exactly 3 cycles later, one cycle wide; out_busy[0]=1; sel_in[0]=4; in_sel_out[4]=0.
3. Same h[4] request with header 16'h0101 → d=4 (LOCAL). Header 16'h0100 → d=3. Header 16'h0001 → d=1.
4. Set h[0] and h[2] together, targets EAST and NORTH, from ptr=4 → input 0 is granted first and input 2 in the next round (ack_h[2] 4 cycles after ack_h[0]). Both outputs end up busy.
5. Input 1 holds EAST (sender[1]=1). Input 3 requests EAST → no ack_h[3] and it retries. Drop sender[1] → EAST released the next cycle, and input 3 is granted in the following round with sel_in[0]=3.
6. Pull reset low while in GRANT with a free destination → no ack_h pulse, out_busy=0, all maps 3'b111.
